// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the serial add/subtract unit.
//   Holds the FSM state encoding used by serial_adder.
// -----------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder, the building block of the serial adder chunk chain.
// Ports
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   co    : carry out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle add/subtract unit. Each RUN cycle adds BITS_PER_CYCLE operand
//   bits (LSB first) through a chain of full adders, with the carry held in a
//   register between cycles. Result is valid with the one-cycle done pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start
//   RUN     | consuming one chunk of operand bits per clock
//   DONE    | one-cycle completion pulse; start accepted here like IDLE
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : operation request, sampled when not busy
//   sub       : 0 add, 1 subtract (a-b), sampled with start
//   a, b      : operands, sampled with start
//   busy      : operation in progress
//   done      : one-cycle completion pulse
//   sum       : result, held until next completion
//   cout      : carry out of MSB (subtract: 1 = no borrow)
//   overflow  : signed overflow
// -----------------------------------------------------------------------------
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1) begin : g_bad_width
      $error("serial_adder: WIDTH must be >= 2 and BITS_PER_CYCLE >= 1");
    end else if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_split
      $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
    end
  endgenerate

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]        r_op_a;
  logic [WIDTH-1:0]        r_op_b;
  logic [WIDTH-1:0]        r_acc;
  logic [WIDTH-1:0]        r_sum;
  logic                    r_carry;
  logic                    r_cout;
  logic                    r_ovf;
  logic [CW-1:0]           r_cnt;

  logic                    w_accept;
  logic                    w_last;
  logic [BITS_PER_CYCLE:0] w_c;
  logic [BITS_PER_CYCLE-1:0] w_s;
  logic [WIDTH-1:0]        w_acc_next;

  assign w_c[0] = r_carry;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_chain
      full_adder u_fa (
        .a   (r_op_a[gi]),
        .b   (r_op_b[gi]),
        .cin (w_c[gi]),
        .s   (w_s[gi]),
        .co  (w_c[gi+1])
      );
    end

    // Partial sum enters from the top so that after N steps the first chunk
    // has been shifted down to bit 0.
    if (BITS_PER_CYCLE == WIDTH) begin : g_acc_flat
      assign w_acc_next = w_s;
    end else begin : g_acc_shift
      assign w_acc_next = {w_s, r_acc[WIDTH-1:BITS_PER_CYCLE]};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        done = (r_state == ST_DONE);
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_cnt == LP_LAST) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        // Subtract is a + ~b + 1: invert B and seed the carry with 1.
        r_op_a  <= a;
        r_op_b  <= sub ? ~b : b;
        r_carry <= sub;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_op_a  <= r_op_a >> BITS_PER_CYCLE;
        r_op_b  <= r_op_b >> BITS_PER_CYCLE;
        r_acc   <= w_acc_next;
        r_carry <= w_c[BITS_PER_CYCLE];
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          // On the last chunk the top full adder sits on bit WIDTH-1.
          r_sum  <= w_acc_next;
          r_cout <= w_c[BITS_PER_CYCLE];
          r_ovf  <= w_c[BITS_PER_CYCLE-1] ^ w_c[BITS_PER_CYCLE];
        end
      end
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule
